// File: rtl/fir_decim_requant_if.sv
// Sample stream into the requantiser and valid/ready output stream out of its FIFO.
interface fir_decim_requant_if #(
   parameter int unsigned IW = 26,
   parameter int unsigned OW = 16
);
   logic          valid_in;
   logic [IW-1:0] din;
   logic          ready_out;
   logic [OW-1:0] dout;
   logic          valid_out;

   // master: the side that feeds filter samples and consumes FIFO output
   modport master (output valid_in, din, ready_out, input dout, valid_out);
   modport slave  (input valid_in, din, ready_out, output dout, valid_out);
endinterface

// File: rtl/fir_decim_requant.sv
// FIR output stage: decimate by DECIM, round off FRAC_DROP LSBs, saturate to
// OUTPUT_WIDTH and buffer in a first-word-fall-through FIFO with sticky flags.
module fir_decim_requant #(
   parameter int unsigned INPUT_WIDTH  = 26,
   parameter int unsigned OUTPUT_WIDTH = 16,
   parameter int unsigned FRAC_DROP    = 10,
   parameter int unsigned DECIM        = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   fir_decim_requant_if.slave            bus,
   input  logic                          phase_clr,
   input  logic                          sat_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          sat_flag,
   output logic                          overrun
);
   localparam int unsigned RW = INPUT_WIDTH - FRAC_DROP + 1;
   localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [INPUT_WIDTH:0]  RND     = (INPUT_WIDTH+1)'((2**FRAC_DROP) / 2);
   localparam logic signed [RW-1:0]  SAT_MAX = RW'((2**(OUTPUT_WIDTH-1)) - 1);
   localparam logic signed [RW-1:0]  SAT_MIN = ~SAT_MAX;
   localparam logic [PW-1:0]         PH_LAST = PW'(DECIM - 1);
   localparam logic [LW-1:0]         FULL    = LW'(FIFO_DEPTH);

   logic [PW-1:0]            phase_q, phase_d, cur_phase;
   logic                     keep;
   logic                     s1_valid_q, s1_valid_d;
   logic signed [RW-1:0]     s1_r_q, s1_r_d;
   logic [INPUT_WIDTH:0]     rnd_sum;
   logic [OUTPUT_WIDTH-1:0]  wr_data;
   logic                     clip;
   logic [OUTPUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [OUTPUT_WIDTH-1:0]  mem_d [FIFO_DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]            level_q, level_d;
   logic [OUTPUT_WIDTH-1:0]  dout_q, dout_d;
   logic                     valid_q, valid_d;
   logic                     sat_q, sat_d, ovr_q, ovr_d;
   logic                     do_pop, do_wr, drop;

   // Decimation phase; phase_clr makes this cycle behave as phase 0
   always_comb begin
      cur_phase = phase_clr ? '0 : phase_q;
      keep      = bus.valid_in && (cur_phase == '0);
      phase_d   = cur_phase;
      if (bus.valid_in) begin
         phase_d = (cur_phase == PH_LAST) ? '0 : cur_phase + PW'(1);
      end
   end

   // Stage 1: round half toward +inf on a sign-extended copy, so no overflow
   always_comb begin
      rnd_sum    = {bus.din[INPUT_WIDTH-1], bus.din} + RND;
      s1_valid_d = keep;
      s1_r_d     = s1_r_q;
      if (keep) begin
         s1_r_d = RW'($signed(rnd_sum) >>> FRAC_DROP);
      end
   end

   // Stage 2: saturate the registered rounded value
   always_comb begin
      clip    = 1'b0;
      wr_data = OUTPUT_WIDTH'(s1_r_q);
      if (s1_r_q > SAT_MAX) begin
         clip    = 1'b1;
         wr_data = OUTPUT_WIDTH'(SAT_MAX);
      end else if (s1_r_q < SAT_MIN) begin
         clip    = 1'b1;
         wr_data = OUTPUT_WIDTH'(SAT_MIN);
      end
   end

   // FIFO update; dout/valid_out are registered from the post-update head
   always_comb begin
      do_pop   = (level_q != '0) && bus.ready_out;
      do_wr    = s1_valid_q && ((level_q != FULL) || do_pop);
      drop     = s1_valid_q && !do_wr;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_wr && !do_pop) begin
         level_d = level_q + LW'(1);
      end else if (!do_wr && do_pop) begin
         level_d = level_q - LW'(1);
      end
      valid_d = (level_d != '0);
      dout_d  = valid_d ? mem_d[rd_ptr_d] : '0;
      sat_d   = (sat_q && !sat_clr) || (s1_valid_q && clip);
      ovr_d   = (ovr_q && !sat_clr) || drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_r_q     <= '0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         sat_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         s1_valid_q <= s1_valid_d;
         s1_r_q     <= s1_r_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         sat_q      <= sat_d;
         ovr_q      <= ovr_d;
      end
   end

   assign bus.dout      = dout_q;
   assign bus.valid_out = valid_q;
   assign fifo_level    = level_q;
   assign sat_flag      = sat_q;
   assign overrun       = ovr_q;
endmodule
